countdown_timer: RTL
====================

Name: countdown_timer

Overview:
Down-counting companion to the team's up-counting stopwatch. It is loaded with a start value, decrements once every TICK_DIV clock cycles while enabled, and pauses and resumes on run_i. On reaching zero it raises a fixed-length alarm pulse, then holds a sticky done flag until it is cleared or reloaded. It sits beside the stopwatch in the timing/UI datapath and drives the same style of time display.

Parameters:
WIDTH, 8, width of the time value and time_o.
TICK_DIV, 1, clock cycles per decrement; legal range >=1.
ALARM_CYCLES, 4, number of cycles alarm_o stays high after expiry; legal range >=1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
reset_i  input  1  synchronous, active-high reset.
load_i  input  1  load value_i into the counter; returns to STOPPED.
value_i  input  WIDTH  start value; sampled only when load_i=1.
run_i  input  1  level enable: count while high, pause while low.
clear_i  input  1  force time to 0 and return to STOPPED.
time_o  output  WIDTH  current remaining time (registered).
running_o  output  1  high in RUNNING.
alarm_o  output  1  high in ALARM.
done_o  output  1  high in ALARM and DONE.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk_i.
- Reset state: STOPPED, time=0, prescaler div=0, alarm counter=0. Outputs after reset: time_o=0, running_o=0, alarm_o=0, done_o=0.
- Input priority in every state, evaluated each edge: clear_i > load_i > run_i.
  - clear_i: time=0, div=0, state becomes STOPPED.
  - load_i (no clear_i): time=value_i, div=0, state becomes STOPPED.
- All outputs decode directly from registers. There is no combinational path from any input to any output.
- States: STOPPED, RUNNING, ALARM, DONE. Encoding is free.
- STOPPED:
  - run_i=1 and time!=0: go to RUNNING. div is kept, so a paused count resumes mid-period.
  - run_i=1 and time=0: stay in STOPPED. No alarm.
  - Otherwise hold.
- RUNNING:
  - run_i=0: go to STOPPED. time and div are held.
  - Otherwise, if div==TICK_DIV-1: div=0 and time=time-1. Else div=div+1.
  - Expiry: the decrement that takes time from 1 to 0 also moves the state to ALARM and sets alarm counter=ALARM_CYCLES-1. That happens in the same edge.
  - No wrap-around: time never decrements below 0.
- ALARM:
  - run_i is ignored.
  - Alarm counter decrements each cycle. On the edge where it reads 0, go to DONE.
  - Result: alarm_o is high for exactly ALARM_CYCLES cycles.
- DONE: hold, with time=0 and done_o=1. Exit only through clear_i or load_i. run_i is ignored.
- Latency, TICK_DIV=1, value V: run_i high at edge k puts the block in RUNNING after edge k. time_o reads V-n after edge k+n. ALARM is entered after edge k+V.
- General TICK_DIV, starting from div=0: each decrement takes TICK_DIV cycles, so expiry occurs after edge k+V*TICK_DIV.
- Simultaneous events:
  - load_i together with run_i: the load wins, and the block stays STOPPED for that edge.
  - clear_i together with load_i: the clear wins, giving time=0.
  - Reset asserted mid-count: the reset state is restored on the next edge.
- Loading value 0 and then running: the block stays in STOPPED.

Test Plan:
- Reset: hold reset_i for 2 cycles while run_i=1 and load_i=1 -> time_o=0 and all flags 0 the cycle after release.
- Basic countdown, TICK_DIV=1, ALARM_CYCLES=4: load 3, then run_i=1 -> time_o sequence 3,2,1,0 on consecutive edges; alarm_o high exactly 4 cycles; then done_o=1 and alarm_o=0 held indefinitely.
- Prescaler, TICK_DIV=3: load 2, run -> time_o changes every 3 cycles; ALARM entered 6 edges after RUNNING entry.
- Pause and resume, TICK_DIV=3: drop run_i mid-period for 5 cycles -> time_o frozen and running_o=0; after re-raise, the next decrement completes the remaining div period (not a full 3).
- Priority: assert clear_i and load_i (value 9) together while RUNNING at time 5 -> time_o=0, STOPPED. Then load_i and run_i together with value 7 -> time_o=7, running_o=0 on that edge, RUNNING on the next.
- Zero and exit paths: load 0 and run -> stays STOPPED, no alarm. In DONE, load 4 -> STOPPED with time_o=4 and done_o=0. clear_i during ALARM -> alarm_o drops the next cycle and time_o=0.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: prescaled down-counter with a fixed-length alarm pulse and a sticky done flag
module countdown_timer #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 1,
  parameter int ALARM_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             run_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] time_o,
  output logic             running_o,
  output logic             alarm_o,
  output logic             done_o
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int AW = ALARM_CYCLES > 1 ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ACNT_INIT = AW'(ALARM_CYCLES - 1);
  typedef enum logic [1:0] {STOPPED, RUNNING, ALARM, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] time_q, time_n;
  logic [DW-1:0] div, div_n;
  logic [AW-1:0] acnt, acnt_n;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= STOPPED;
      time_q <= '0;
      div    <= '0;
      acnt   <= '0;
    end else begin
      state  <= state_n;
      time_q <= time_n;
      div    <= div_n;
      acnt   <= acnt_n;
    end
  end
  always_comb begin
    state_n = state;
    time_n  = time_q;
    div_n   = div;
    acnt_n  = acnt;
    if (clear_i) begin
      state_n = STOPPED;
      time_n  = '0;
      div_n   = '0;
    end else if (load_i) begin
      state_n = STOPPED;
      time_n  = value_i;
      div_n   = '0;
    end else begin
      case (state)
        STOPPED: state_n = (run_i && time_q != '0) ? RUNNING : STOPPED;
        RUNNING: begin
          if (!run_i) state_n = STOPPED;
          else if (div == DIV_LAST) begin
            div_n  = '0;
            time_n = (time_q != '0) ? time_q - WIDTH'(1) : time_q;
            // the final decrement enters ALARM on the same edge
            if (time_q == WIDTH'(1)) begin
              state_n = ALARM;
              acnt_n  = ACNT_INIT;
            end
          end else div_n = div + DW'(1);
        end
        ALARM: begin
          state_n = (acnt == '0) ? DONE : ALARM;
          acnt_n  = (acnt == '0) ? acnt : acnt - AW'(1);
        end
        default: ;
      endcase
    end
  end
  assign time_o    = time_q;
  assign running_o = state == RUNNING;
  assign alarm_o   = state == ALARM;
  assign done_o    = state == ALARM || state == DONE;
endmodule
